// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder with programmable wait states.
// Accepts one load/store at a time, waits WAIT_CYCLES, accesses an internal
// word array with byte/half/word granularity and returns data or an error.
module dmem_responder #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned WAIT_CYCLES = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  req_funct3,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int unsigned AW   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

   typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

   state_t      state;
   logic [3:0]  cnt;
   logic        lat_we;
   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;
   logic [2:0]  lat_funct3;
   logic [31:0] mem [DEPTH_WORDS];

   logic [31:0]   offset;
   logic [AW-1:0] idx;
   logic [1:0]    lane;
   logic          out_of_range;
   logic          access_err;
   logic [31:0]   rd_word;
   logic [3:0]    wr_be;
   logic [31:0]   wr_data;

   // Halfword needs addr[0]=0, word needs addr[1:0]=0; bytes never misalign.
   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] ln);
      case (f3[1:0])
         2'b01:   return ln[0];
         2'b10:   return (ln != 2'b00);
         default: return 1'b0;
      endcase
   endfunction

   // Loads allow 000/001/010/100/101; stores allow only 000/001/010.
   function automatic logic is_illegal(input logic we, input logic [2:0] f3);
      if (we)
         return (f3 > 3'b010);
      else
         return (f3 == 3'b011) || (f3[2:1] == 2'b11);
   endfunction

   // Select the addressed byte/half and sign- or zero-extend it.
   function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [1:0] ln,
                                              input logic [2:0] f3);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[{ln, 3'b000} +: 8];
      h = ln[1] ? w[31:16] : w[15:0];
      case (f3)
         3'b000:  return {{24{b[7]}}, b};
         3'b001:  return {{16{h[15]}}, h};
         3'b010:  return w;
         3'b100:  return {24'h0, b};
         3'b101:  return {16'h0, h};
         default: return 32'h0;
      endcase
   endfunction

   // Byte-lane enables for a store of the given width at the given lane.
   function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] ln);
      case (f3)
         3'b000:  return 4'b0001 << ln;
         3'b001:  return ln[1] ? 4'b1100 : 4'b0011;
         3'b010:  return 4'b1111;
         default: return 4'b0000;
      endcase
   endfunction

   // Replicate right-aligned store data onto every lane it could occupy.
   function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
      case (f3)
         3'b000:  return {4{d[7:0]}};
         3'b001:  return {2{d[15:0]}};
         default: return d;
      endcase
   endfunction

   assign req_ready    = (state == IDLE);
   assign offset       = lat_addr - BASE_ADDR;
   assign idx          = offset[AW+1:2];
   assign lane         = lat_addr[1:0];
   assign out_of_range = (lat_addr < BASE_ADDR) || ({1'b0, offset} >= SPAN);
   assign access_err   = out_of_range || is_misaligned(lat_funct3, lane) ||
                         is_illegal(lat_we, lat_funct3);
   assign rd_word      = mem[idx];
   assign wr_be        = store_be(lat_funct3, lane);
   assign wr_data      = store_data(lat_funct3, lat_wdata);

   // Capture the request fields only in the acceptance cycle.
   always_ff @(posedge clk) begin
      if (state == IDLE && req_valid) begin
         lat_we     <= req_we;
         lat_addr   <= req_addr;
         lat_wdata  <= req_wdata;
         lat_funct3 <= req_funct3;
      end
   end

   // Array write happens only in the ACCESS cycle of an error-free store.
   always_ff @(posedge clk) begin
      if (state == ACCESS && lat_we && !access_err) begin
         for (int i = 0; i < 4; i++) begin
            if (wr_be[i])
               mem[idx][8*i +: 8] <= wr_data[8*i +: 8];
         end
      end
   end

   // Request/response FSM with registered response outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'h0;
         rsp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  if (WAIT_CYCLES > 0) begin
                     cnt   <= 4'(WAIT_CYCLES - 1);
                     state <= WAIT;
                  end else begin
                     state <= ACCESS;
                  end
               end
            end
            WAIT: begin
               if (cnt == 4'd0)
                  state <= ACCESS;
               else
                  cnt <= cnt - 4'd1;
            end
            ACCESS: begin
               rsp_err   <= access_err;
               rsp_rdata <= (access_err || lat_we) ? 32'h0
                                                   : load_extend(rd_word, lane, lat_funct3);
               rsp_valid <= 1'b1;
               state     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed table-driven bench for dmem_responder with a
// WAIT_CYCLES=2 instance (a) and a WAIT_CYCLES=0 instance (b) sharing stimulus.
module tb_dmem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        sel;
   logic        req_valid, req_we, rsp_ready;
   logic [31:0] req_addr, req_wdata;
   logic [2:0]  req_funct3;

   logic        ready_a, valid_a, err_a, ready_b, valid_b, err_b;
   logic [31:0] rdata_a, rdata_b;
   logic        req_valid_a, req_valid_b, rsp_ready_a, rsp_ready_b;
   logic        req_ready, rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;

   assign req_valid_a = req_valid & ~sel;
   assign req_valid_b = req_valid & sel;
   assign rsp_ready_a = rsp_ready & ~sel;
   assign rsp_ready_b = rsp_ready & sel;
   assign req_ready   = sel ? ready_b : ready_a;
   assign rsp_valid   = sel ? valid_b : valid_a;
   assign rsp_err     = sel ? err_b   : err_a;
   assign rsp_rdata   = sel ? rdata_b : rdata_a;

   dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) dut_a (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid_a), .req_ready(ready_a),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
      .rsp_valid(valid_a), .rsp_ready(rsp_ready_a), .rsp_rdata(rdata_a), .rsp_err(err_a));

   dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) dut_b (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid_b), .req_ready(ready_b),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
      .rsp_valid(valid_b), .rsp_ready(rsp_ready_b), .rsp_rdata(rdata_b), .rsp_err(err_b));

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      bit          use_b;
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs[28];

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      n_cmp++;
      n_fail++;
      $display("FAIL %s: timed out waiting for DUT", name);
   endtask

   // One full transaction; returns data, error and cycles from accept to rsp_valid.
   task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] f3, output logic [31:0] rdata,
                         output logic err, output int lat);
      int guard;
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_funct3 = f3;
      guard = 0;
      while (!req_ready && guard < 50) begin @(posedge clk); #1; guard++; end
      if (guard >= 50) timeout("accept");
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_we = ~we; req_addr = addr ^ 32'h4; req_wdata = ~wdata; req_funct3 = f3 ^ 3'b001;
      check32("ready_low_after_accept", 32'(req_ready), 32'd0);
      lat = 1; guard = 0;
      while (!rsp_valid && guard < 50) begin @(posedge clk); #1; lat++; guard++; end
      if (guard >= 50) timeout("rsp_valid");
      rdata = rsp_rdata;
      err   = rsp_err;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      check32("valid_clear_after_handshake", 32'(rsp_valid), 32'd0);
   endtask

   initial begin
      logic [31:0] rd, hold_rd;
      logic        er, hold_er;
      int          lat, guard;

      vecs[0]  = '{0, 1'b1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h00000000, 1'b0};
      vecs[1]  = '{0, 1'b0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
      vecs[2]  = '{0, 1'b1, 3'b000, 32'h11,  32'h000000A5, 32'h00000000, 1'b0};
      vecs[3]  = '{0, 1'b0, 3'b000, 32'h11,  32'h0,        32'hFFFFFFA5, 1'b0};
      vecs[4]  = '{0, 1'b0, 3'b100, 32'h11,  32'h0,        32'h000000A5, 1'b0};
      vecs[5]  = '{0, 1'b0, 3'b001, 32'h12,  32'h0,        32'hFFFFDEAD, 1'b0};
      vecs[6]  = '{0, 1'b0, 3'b101, 32'h12,  32'h0,        32'h0000DEAD, 1'b0};
      vecs[7]  = '{0, 1'b0, 3'b010, 32'h10,  32'h0,        32'hDEADA5EF, 1'b0};
      vecs[8]  = '{0, 1'b0, 3'b010, 32'h13,  32'h0,        32'h00000000, 1'b1};
      vecs[9]  = '{0, 1'b1, 3'b001, 32'h11,  32'h0000FFFF, 32'h00000000, 1'b1};
      vecs[10] = '{0, 1'b0, 3'b011, 32'h10,  32'h0,        32'h00000000, 1'b1};
      vecs[11] = '{0, 1'b1, 3'b011, 32'h10,  32'hFFFFFFFF, 32'h00000000, 1'b1};
      vecs[12] = '{0, 1'b0, 3'b010, 32'h10,  32'h0,        32'hDEADA5EF, 1'b0};
      vecs[13] = '{0, 1'b1, 3'b010, 32'h0,   32'hCAFEF00D, 32'h00000000, 1'b0};
      vecs[14] = '{0, 1'b1, 3'b010, 32'h400, 32'h00000001, 32'h00000000, 1'b1};
      vecs[15] = '{0, 1'b0, 3'b010, 32'h0,   32'h0,        32'hCAFEF00D, 1'b0};
      vecs[16] = '{0, 1'b0, 3'b010, 32'h400, 32'h0,        32'h00000000, 1'b1};
      vecs[17] = '{0, 1'b0, 3'b110, 32'h10,  32'h0,        32'h00000000, 1'b1};
      vecs[18] = '{0, 1'b0, 3'b001, 32'h10,  32'h0,        32'hFFFFA5EF, 1'b0};
      vecs[19] = '{0, 1'b0, 3'b000, 32'h13,  32'h0,        32'hFFFFFFDE, 1'b0};
      vecs[20] = '{0, 1'b0, 3'b100, 32'h10,  32'h0,        32'h000000EF, 1'b0};
      vecs[21] = '{0, 1'b1, 3'b001, 32'h12,  32'hABCD1234, 32'h00000000, 1'b0};
      vecs[22] = '{0, 1'b0, 3'b010, 32'h10,  32'h0,        32'h1234A5EF, 1'b0};
      vecs[23] = '{1, 1'b1, 3'b010, 32'h8,   32'h89ABCDEF, 32'h00000000, 1'b0};
      vecs[24] = '{1, 1'b0, 3'b001, 32'h8,   32'h0,        32'hFFFFCDEF, 1'b0};
      vecs[25] = '{1, 1'b0, 3'b000, 32'hB,   32'h0,        32'hFFFFFF89, 1'b0};
      vecs[26] = '{1, 1'b0, 3'b101, 32'hA,   32'h0,        32'h000089AB, 1'b0};
      vecs[27] = '{1, 1'b0, 3'b010, 32'h9,   32'h0,        32'h00000000, 1'b1};

      sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; rsp_ready = 1'b0;
      req_addr = 32'h0; req_wdata = 32'h0; req_funct3 = 3'b0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check32("reset_valid_a", 32'(valid_a), 32'd0);
      check32("reset_rdata_a", rdata_a, 32'h0);
      check32("reset_err_a",   32'(err_a), 32'd0);
      check32("reset_ready_a", 32'(ready_a), 32'd1);
      check32("reset_valid_b", 32'(valid_b), 32'd0);
      #1 rst_n = 1'b1;

      // Directed vector table
      for (int i = 0; i < 28; i++) begin
         sel = vecs[i].use_b;
         do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].f3, rd, er, lat);
         check32($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
         check32($sformatf("v%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
         check32($sformatf("v%0d_latency", i), 32'(lat), vecs[i].use_b ? 32'd2 : 32'd4);
      end
      sel = 1'b0;

      // Response stall with a competing request held high throughout
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_funct3 = 3'b010;
      check32("stall_ready_idle", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      req_addr = 32'h0;
      guard = 0;
      while (!rsp_valid && guard < 50) begin @(posedge clk); #1; guard++; end
      if (guard >= 50) timeout("stall_rsp");
      hold_rd = rsp_rdata; hold_er = rsp_err;
      check32("stall_first_rdata", hold_rd, 32'h1234A5EF);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         check32($sformatf("stall%0d_valid", k), 32'(rsp_valid), 32'd1);
         check32($sformatf("stall%0d_rdata", k), rsp_rdata, hold_rd);
         check32($sformatf("stall%0d_err", k), 32'(rsp_err), 32'(hold_er));
         check32($sformatf("stall%0d_ready", k), 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      check32("stall_valid_drop", 32'(rsp_valid), 32'd0);
      check32("stall_ready_back", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      check32("b2b_accepted", 32'(req_ready), 32'd0);
      req_valid = 1'b0;
      guard = 0;
      while (!rsp_valid && guard < 50) begin @(posedge clk); #1; guard++; end
      if (guard >= 50) timeout("b2b_rsp");
      check32("b2b_rdata", rsp_rdata, 32'hCAFEF00D);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;

      // Reset during WAIT drops the pending store
      do_req(1'b1, 32'h20, 32'h0BADF00D, 3'b010, rd, er, lat);
      check32("pre_store_err", 32'(er), 32'd0);
      do_req(1'b0, 32'h10, 32'h0, 3'b010, rd, er, lat);
      check32("pre_load_rdata", rd, 32'h1234A5EF);
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678;
      req_funct3 = 3'b010;
      @(posedge clk); #1;
      req_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check32("arst_valid", 32'(rsp_valid), 32'd0);
      check32("arst_rdata", rsp_rdata, 32'h0);
      check32("arst_err", 32'(rsp_err), 32'd0);
      check32("arst_ready", 32'(req_ready), 32'd1);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check32("arst_no_response", 32'(rsp_valid), 32'd0);
      do_req(1'b0, 32'h20, 32'h0, 3'b010, rd, er, lat);
      check32("arst_store_dropped", rd, 32'h0BADF00D);
      check32("arst_load_err", 32'(er), 32'd0);

      // Zero-wait instance: reset while a response is pending
      sel = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h8; req_funct3 = 3'b010;
      @(posedge clk); #1;
      req_valid = 1'b0;
      guard = 0;
      while (!rsp_valid && guard < 50) begin @(posedge clk); #1; guard++; end
      if (guard >= 50) timeout("w0_rsp");
      check32("w0_rsp_rdata", rsp_rdata, 32'h89ABCDEF);
      #2 rst_n = 1'b0;
      #1;
      check32("w0_arst_valid", 32'(rsp_valid), 32'd0);
      check32("w0_arst_rdata", rsp_rdata, 32'h0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      do_req(1'b0, 32'h8, 32'h0, 3'b010, rd, er, lat);
      check32("w0_after_rdata", rd, 32'h89ABCDEF);
      check32("w0_after_latency", 32'(lat), 32'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, limit 200000 required");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the core's data-memory port. It accepts one load/store request at a time over a valid/ready handshake and applies a programmable number of wait states.
- It performs byte/half/word access on an internal word array, including load sign/zero extension. It returns a response with data or an error flag.
- It sits between the core's load/store path and a multi-cycle data RAM. It replaces the zero-latency data memory when wait-state timing is exercised.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the array (power of 2).
- WAIT_CYCLES, 2, extra cycles between request acceptance and response (0..15).
- BASE_ADDR, 32'h0000_0000, byte address mapped to word 0.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned (low byte/half used for SB/SH).
- req_funct3  input  3  RV32I width code.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester consumes response.
- rsp_rdata  output  32  load result, extended; 0 for stores and errors.
- rsp_err  output  1  misaligned, out-of-range or illegal funct3.

Behaviour:
- Reset is asynchronous: rst_n low forces the FSM to IDLE, with rsp_valid=0, rsp_rdata=0, rsp_err=0 and the wait counter at 0. Array contents are not reset.
- req_ready = (state==IDLE). It is combinational from state only.
- FSM IDLE: on req_valid&&req_ready, latch we/addr/wdata/funct3. Go to WAIT if WAIT_CYCLES>0 (counter loaded with WAIT_CYCLES-1), otherwise go to ACCESS.
- FSM WAIT: decrement the counter each cycle. At 0, go to ACCESS.
- FSM ACCESS: a single cycle. Perform the array read/write and register rsp_rdata/rsp_err, then go to RESP.
- FSM RESP: rsp_valid=1; rsp_rdata and rsp_err are held stable until rsp_ready. On rsp_valid&&rsp_ready, go to IDLE and clear rsp_valid.
- Latency: with acceptance at cycle T, rsp_valid first rises at cycle T+WAIT_CYCLES+2. The next request can be accepted the cycle after the response handshake.
- Word index = (addr-BASE_ADDR)>>2; byte lane = addr[1:0].
- Out of range: (addr-BASE_ADDR) >= 4*DEPTH_WORDS (unsigned), or addr<BASE_ADDR.
- Loads: LB 000 sign-extends the selected byte. LH 001 sign-extends the selected half. LW 010 returns the word. LBU 100 and LHU 101 zero-extend.
- Stores: SB 000 writes one byte lane. SH 001 writes lanes {1,0} or {3,2}. SW 010 writes all lanes. Other lanes are unchanged.
- Misaligned: half with addr[0]=1; word with addr[1:0]!=0.
- Illegal funct3: loads 011/110/111; stores any value other than 000/001/010.
- Error cases: rsp_err=1, rsp_rdata=0, and no array write occurs.
- Successful store: rsp_err=0, rsp_rdata=0. The write commits in the ACCESS cycle, so a later load observes it.
- Request inputs are ignored outside the IDLE acceptance cycle. Changing them during WAIT/RESP has no effect.
- rsp_ready asserted while rsp_valid=0 has no effect.
- Reset mid-operation (WAIT or ACCESS pending): the write is dropped if ACCESS was not yet clocked, and no response is produced.
- Back-to-back requests: req_valid held high across a response handshake is accepted in the IDLE cycle that follows.

Test Plan:
- Reset then SW addr 0x10 data 0xDEADBEEF, then LW 0x10 (WAIT_CYCLES=2) -> req_ready low after acceptance; rsp_valid rises exactly 4 cycles after each accept; LW returns 0xDEADBEEF, rsp_err=0.
- After the above, SB 0x11 data 0x000000A5, then LB 0x11, LBU 0x11, LH 0x12, LHU 0x12 -> 0xFFFFFFA5, 0x000000A5, 0xFFFFDEAD, 0x0000DEAD; word 0x10 reads 0xDEADA5EF.
- LW 0x13, SH 0x11, load funct3 011 -> each gives rsp_err=1 and rsp_rdata=0; a subsequent LW 0x10 is unchanged (0xDEADA5EF).
- Address 4*DEPTH_WORDS (0x400) with SW data 0x1 -> rsp_err=1. Then LW 0x0 -> previous contents; no wrap-around write occurred.
- rsp_ready held low 5 cycles during RESP -> rsp_valid/rsp_rdata/rsp_err stable; req_ready stays 0 and a concurrent req_valid is not accepted until the cycle after the handshake.
- SW 0x20 data 0x12345678 with rst_n pulsed low during WAIT -> outputs zero immediately (asynchronous), no response; LW 0x20 after reset returns the prior value, not 0x12345678. Repeat with WAIT_CYCLES=0: latency is 2 cycles.
